hpi_controller: RTL and testbench

Host-side controller for the Cypress CY7C67300 Host Port Interface (HPI). It holds the chip in reset after power-up, then drives single-word HPI bus cycles. On a manual trigger (splat) it runs a RAM self-test: it writes a word pattern into CY7C67300 RAM through the HPI, reads it back and reports pass/fail. It sits between the FPGA core clock domain and the external USB chip pins.

---
 rtl/hpi_pkg.sv | 43 ++++
 rtl/hpi_if.sv | 38 +++
 rtl/hpi_bus_cycle.sv | 130 +++++++++++++
 rtl/hpi_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_hpi_controller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hpi_pkg
// Brief    : Shared constants, state encodings and the self-test word pattern
//            for the CY7C67300 Host Port Interface controller.
// Revision : 1.0 - initial release
// ============================================================================
package hpi_pkg;

    // HPI port select values driven on hpi_address
    localparam logic [1:0] HPI_DATA    = 2'b00;
    localparam logic [1:0] HPI_MAILBOX = 2'b01;
    localparam logic [1:0] HPI_ADDR    = 2'b10;
    localparam logic [1:0] HPI_STATUS  = 2'b11;

    // Top-level sequencing states
    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_BOOT_WAIT = 3'd1,
        ST_IDLE      = 3'd2,
        ST_WR_PTR    = 3'd3,
        ST_WR_DATA   = 3'd4,
        ST_RD_PTR    = 3'd5,
        ST_RD_DATA   = 3'd6,
        ST_DONE      = 3'd7
    } hpi_state_t;

    // Phases of a single HPI bus access
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SETUP  = 3'd1,
        PH_STROBE = 3'd2,
        PH_HOLD   = 3'd3,
        PH_GAP    = 3'd4
    } hpi_phase_t;

    // Self-test word for index idx: index in the high byte, its complement low
    function automatic logic [15:0] test_pattern(input logic [7:0] idx);
        return {idx, ~idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpi_if.sv
`default_nettype none
// ============================================================================
// Module   : hpi_if
// Brief    : Control-side pins of the CY7C67300 HPI (reset, strobes, port
//            select, interrupt). The data bus stays a separate inout port.
// Revision : 1.0 - initial release
// ============================================================================
interface hpi_if;

    logic       hpi_resetn;
    logic       hpi_csn;
    logic       hpi_oen;
    logic       hpi_wen;
    logic       hpi_irq;
    logic [1:0] hpi_address;

    // Host controller side
    modport master (
        output hpi_resetn,
        output hpi_csn,
        output hpi_oen,
        output hpi_wen,
        output hpi_address,
        input  hpi_irq
    );

    // Chip (or chip model) side
    modport slave (
        input  hpi_resetn,
        input  hpi_csn,
        input  hpi_oen,
        input  hpi_wen,
        input  hpi_address,
        output hpi_irq
    );

endinterface
`default_nettype wire

// File: rtl/hpi_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module   : hpi_bus_cycle
// Brief    : Runs one HPI access: SETUP, STROBE, HOLD, GAP. All pin outputs
//            are registered and derived from the next phase so they line up
//            exactly with the phase register. A new access may be launched
//            from GAP so back-to-back accesses keep csn high for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module hpi_bus_cycle
    import hpi_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4
) (
    input  wire logic        sys_clk,
    input  wire logic        usbreset,
    input  wire logic        i_start,
    input  wire logic        i_rnw,
    input  wire logic [1:0]  i_addr,
    input  wire logic [15:0] i_wdata,
    input  wire logic [15:0] i_din,
    output logic             o_csn,
    output logic             o_oen,
    output logic             o_wen,
    output logic [1:0]       o_address,
    output logic [15:0]      o_dout,
    output logic             o_doe,
    output logic [15:0]      o_rdata,
    output logic             o_done
);

    localparam logic [7:0] c_setup_last  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] c_strobe_last = 8'(STROBE_CYCLES - 1);

    hpi_phase_t r_phase;
    hpi_phase_t w_phase_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_rnw;
    logic       w_launch;
    logic       w_rnw_eff;
    logic       w_active_nxt;

    // Next phase, cycle counter and launch decision
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (i_start) begin
                    w_launch    = 1'b1;
                    w_phase_nxt = PH_SETUP;
                    w_cnt_nxt   = 8'd0;
                end
            end
            PH_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_phase_nxt = PH_STROBE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            PH_STROBE: begin
                if (r_cnt == c_strobe_last) begin
                    w_phase_nxt = PH_HOLD;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            PH_HOLD: begin
                w_phase_nxt = PH_GAP;
            end
            PH_GAP: begin
                w_cnt_nxt = 8'd0;
                if (i_start) begin
                    w_launch    = 1'b1;
                    w_phase_nxt = PH_SETUP;
                end else begin
                    w_phase_nxt = PH_IDLE;
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
        w_rnw_eff    = w_launch ? i_rnw : r_rnw;
        w_active_nxt = (w_phase_nxt == PH_SETUP) || (w_phase_nxt == PH_STROBE) ||
                       (w_phase_nxt == PH_HOLD);
    end

    // Phase register and registered pin outputs
    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) begin
            r_phase   <= PH_IDLE;
            r_cnt     <= 8'd0;
            r_rnw     <= 1'b1;
            o_csn     <= 1'b1;
            o_oen     <= 1'b1;
            o_wen     <= 1'b1;
            o_address <= HPI_DATA;
            o_dout    <= 16'h0000;
            o_doe     <= 1'b0;
            o_rdata   <= 16'h0000;
            o_done    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_launch) begin
                r_rnw     <= i_rnw;
                o_address <= i_addr;
                o_dout    <= i_wdata;
            end
            o_csn  <= ~w_active_nxt;
            o_oen  <= ~((w_phase_nxt == PH_STROBE) && w_rnw_eff);
            o_wen  <= ~((w_phase_nxt == PH_STROBE) && !w_rnw_eff);
            o_doe  <= w_active_nxt && !w_rnw_eff;
            o_done <= (w_phase_nxt == PH_GAP);
            if ((r_phase == PH_STROBE) && (r_cnt == c_strobe_last)) begin
                o_rdata <= i_din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpi_controller.sv
`default_nettype none
// ============================================================================
// Module   : hpi_controller
// Brief    : CY7C67300 HPI host controller. Holds the chip in reset, waits
//            for boot, then on a splat rising edge writes a word pattern into
//            chip RAM, reads it back and reports pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module hpi_controller
    import hpi_pkg::*;
#(
    parameter int          RESET_CYCLES  = 64,
    parameter int          BOOT_CYCLES   = 256,
    parameter int          SETUP_CYCLES  = 2,
    parameter int          STROBE_CYCLES = 4,
    parameter logic [15:0] TEST_BASE     = 16'h1000,
    parameter int          TEST_WORDS    = 16
) (
    input  wire logic        sys_clk,
    input  wire logic        usbreset,
    hpi_if.master            hpi,
    inout  wire logic [15:0] hpi_data,
    input  wire logic        splat,
    output logic             test_busy,
    output logic             test_done,
    output logic             test_pass,
    output logic             irq_seen
);

    localparam logic [15:0] c_reset_last = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] c_boot_last  = 16'(BOOT_CYCLES - 1);
    localparam logic [7:0]  c_last_word  = 8'(TEST_WORDS - 1);

    hpi_state_t  r_state;
    hpi_state_t  w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [7:0]  r_word, w_word_nxt;
    logic        r_wait, w_wait_nxt;
    logic        r_fail, w_fail_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_pass, w_pass_nxt;
    logic        r_irq_seen, w_irq_seen_nxt;
    logic        r_resetn, w_resetn_nxt;
    logic        r_splat_s1, r_splat_s2, r_splat_s3;
    logic        r_irq_s1, r_irq_s2;
    logic        w_trig;

    logic        w_go;
    logic        w_req_rnw;
    logic [1:0]  w_req_addr;
    logic [15:0] w_req_wdata;
    logic        w_csn, w_oen, w_wen, w_doe, w_bus_done;
    logic [1:0]  w_address;
    logic [15:0] w_dout, w_rdata;

    hpi_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_bus (
        .sys_clk   (sys_clk),
        .usbreset  (usbreset),
        .i_start   (w_go),
        .i_rnw     (w_req_rnw),
        .i_addr    (w_req_addr),
        .i_wdata   (w_req_wdata),
        .i_din     (hpi_data),
        .o_csn     (w_csn),
        .o_oen     (w_oen),
        .o_wen     (w_wen),
        .o_address (w_address),
        .o_dout    (w_dout),
        .o_doe     (w_doe),
        .o_rdata   (w_rdata),
        .o_done    (w_bus_done)
    );

    assign hpi.hpi_resetn  = r_resetn;
    assign hpi.hpi_csn     = w_csn;
    assign hpi.hpi_oen     = w_oen;
    assign hpi.hpi_wen     = w_wen;
    assign hpi.hpi_address = w_address;
    assign hpi_data        = w_doe ? w_dout : 16'hzzzz;

    assign test_busy = r_busy;
    assign test_done = r_done;
    assign test_pass = r_pass;
    assign irq_seen  = r_irq_seen;

    // Trigger is a rising edge seen after the two-stage synchronizer
    assign w_trig = r_splat_s2 & ~r_splat_s3;

    // Two-flop synchronizers for the asynchronous splat and hpi_irq inputs
    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) begin
            r_splat_s1 <= 1'b0;
            r_splat_s2 <= 1'b0;
            r_splat_s3 <= 1'b0;
            r_irq_s1   <= 1'b0;
            r_irq_s2   <= 1'b0;
        end else begin
            r_splat_s1 <= splat;
            r_splat_s2 <= r_splat_s1;
            r_splat_s3 <= r_splat_s2;
            r_irq_s1   <= hpi.hpi_irq;
            r_irq_s2   <= r_irq_s1;
        end
    end

    // Sequencer next state; an access is started either on entry to a bus
    // state (r_wait low) or in the same cycle the previous access finishes
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_word_nxt     = r_word;
        w_wait_nxt     = r_wait;
        w_fail_nxt     = r_fail;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_irq_seen_nxt = r_irq_seen;
        w_resetn_nxt   = r_resetn;
        w_go           = 1'b0;
        case (r_state)
            ST_RST_HOLD: begin
                if (r_timer == c_reset_last) begin
                    w_state_nxt  = ST_BOOT_WAIT;
                    w_timer_nxt  = 16'd0;
                    w_resetn_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_BOOT_WAIT: begin
                if (r_timer == c_boot_last) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = 16'd0;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt    = ST_WR_PTR;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_irq_seen_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_fail_nxt     = 1'b0;
                    w_word_nxt     = 8'd0;
                    w_wait_nxt     = 1'b0;
                end
            end
            ST_WR_PTR: begin
                if (!r_wait) begin
                    w_go       = 1'b1;
                    w_wait_nxt = 1'b1;
                end else if (w_bus_done) begin
                    w_state_nxt = ST_WR_DATA;
                    w_word_nxt  = 8'd0;
                    w_go        = 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (w_bus_done) begin
                    w_go = 1'b1;
                    if (r_word == c_last_word) begin
                        w_state_nxt = ST_RD_PTR;
                        w_word_nxt  = 8'd0;
                    end else begin
                        w_word_nxt = r_word + 8'd1;
                    end
                end
            end
            ST_RD_PTR: begin
                if (w_bus_done) begin
                    w_state_nxt = ST_RD_DATA;
                    w_word_nxt  = 8'd0;
                    w_go        = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (w_bus_done) begin
                    if (w_rdata != test_pattern(r_word)) begin
                        w_fail_nxt = 1'b1;
                    end
                    if (r_word == c_last_word) begin
                        w_state_nxt = ST_DONE;
                        w_wait_nxt  = 1'b0;
                    end else begin
                        w_word_nxt = r_word + 8'd1;
                        w_go       = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_pass_nxt  = ~r_fail;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_RST_HOLD;
            end
        endcase
        if ((r_state != ST_RST_HOLD) && r_irq_s2) begin
            w_irq_seen_nxt = 1'b1;
        end
    end

    // Parameters of the access being launched follow the state it belongs to
    always_comb begin
        w_req_rnw   = (w_state_nxt == ST_RD_DATA);
        w_req_addr  = HPI_DATA;
        w_req_wdata = test_pattern(w_word_nxt);
        if ((w_state_nxt == ST_WR_PTR) || (w_state_nxt == ST_RD_PTR)) begin
            w_req_addr  = HPI_ADDR;
            w_req_wdata = TEST_BASE;
        end
    end

    // Sequencer and status registers
    always_ff @(posedge sys_clk or posedge usbreset) begin
        if (usbreset) begin
            r_state    <= ST_RST_HOLD;
            r_timer    <= 16'd0;
            r_word     <= 8'd0;
            r_wait     <= 1'b0;
            r_fail     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_irq_seen <= 1'b0;
            r_resetn   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_word     <= w_word_nxt;
            r_wait     <= w_wait_nxt;
            r_fail     <= w_fail_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_irq_seen <= w_irq_seen_nxt;
            r_resetn   <= w_resetn_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hpi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpi_controller
// Brief    : Directed bench for hpi_controller with an auto-incrementing
//            HPI RAM model that can corrupt one word on readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpi_controller;

    logic        sys_clk = 1'b0;
    logic        usbreset;
    logic        splat;
    wire  [15:0] hpi_data;
    logic        test_busy, test_done, test_pass, irq_seen;

    hpi_if u_if ();

    hpi_controller dut (
        .sys_clk   (sys_clk),
        .usbreset  (usbreset),
        .hpi       (u_if.master),
        .hpi_data  (hpi_data),
        .splat     (splat),
        .test_busy (test_busy),
        .test_done (test_done),
        .test_pass (test_pass),
        .irq_seen  (irq_seen)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // HPI RAM model state
    logic [15:0] mem [0:255];
    logic [15:0] r_ptr     = 16'h0000;
    logic        corrupt   = 1'b0;
    logic        r_viol    = 1'b0;
    int          n_acc     = 0;
    int          n_runs    = 0;
    logic [1:0]  acc_port [0:255];
    logic        acc_rnw  [0:255];
    logic [15:0] acc_data [0:255];
    logic        r_prev_oen  = 1'b1;
    logic        r_prev_wen  = 1'b1;
    logic        r_prev_busy = 1'b0;
    logic [7:0]  w_idx;
    logic [15:0] w_rd_val;

    assign w_idx    = 8'((r_ptr - 16'h1000) >> 1);
    assign w_rd_val = (corrupt && (w_idx == 8'd5)) ? (mem[w_idx] ^ 16'h0100) : mem[w_idx];
    assign hpi_data = (u_if.hpi_oen == 1'b0) ? w_rd_val : 16'hzzzz;

    // Chip model: logs every access, tracks the auto-incrementing pointer
    always @(negedge sys_clk) begin
        if (!usbreset) begin
            if (!u_if.hpi_oen && !u_if.hpi_wen) r_viol <= 1'b1;
            if (dut.w_doe && !u_if.hpi_oen)     r_viol <= 1'b1;
            if (r_prev_wen && !u_if.hpi_wen) begin
                acc_port[n_acc % 256] <= u_if.hpi_address;
                acc_rnw[n_acc % 256]  <= 1'b0;
                acc_data[n_acc % 256] <= hpi_data;
                n_acc <= n_acc + 1;
                if (u_if.hpi_address == 2'b10) r_ptr <= hpi_data;
                else if (u_if.hpi_address == 2'b00) mem[w_idx] <= hpi_data;
            end
            if (r_prev_oen && !u_if.hpi_oen) begin
                acc_port[n_acc % 256] <= u_if.hpi_address;
                acc_rnw[n_acc % 256]  <= 1'b1;
                acc_data[n_acc % 256] <= hpi_data;
                n_acc <= n_acc + 1;
            end
            if (((!r_prev_oen && u_if.hpi_oen) || (!r_prev_wen && u_if.hpi_wen)) &&
                (u_if.hpi_address == 2'b00)) begin
                r_ptr <= r_ptr + 16'd2;
            end
            if (!r_prev_busy && test_busy) n_runs <= n_runs + 1;
        end
        r_prev_oen  <= u_if.hpi_oen;
        r_prev_wen  <= u_if.hpi_wen;
        r_prev_busy <= test_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Posedges from reset release until hpi_resetn is seen high
    task automatic count_resetn_low(output int k);
        k = 0;
        while (k < 200) begin
            @(posedge sys_clk);
            k++;
            #1;
            if (u_if.hpi_resetn) break;
        end
    endtask

    int k;
    int base;
    int n_rd;
    logic [15:0] exp_word;

    initial begin
        usbreset       = 1'b0;
        splat          = 1'b0;
        u_if.hpi_irq   = 1'b0;
        #2;
        usbreset = 1'b1;
        #1;
        // Reset state
        check("rst_resetn", 32'(u_if.hpi_resetn), 32'd0);
        check("rst_csn", 32'(u_if.hpi_csn), 32'd1);
        check("rst_oen", 32'(u_if.hpi_oen), 32'd1);
        check("rst_wen", 32'(u_if.hpi_wen), 32'd1);
        check("rst_data_z", 32'(dut.w_doe), 32'd0);
        check("rst_busy", 32'(test_busy), 32'd0);
        check("rst_done", 32'(test_done), 32'd0);
        check("rst_irq_seen", 32'(irq_seen), 32'd0);
        cycles(3);
        usbreset = 1'b0;
        count_resetn_low(k);
        check("rst_hold_len", 32'(k), 32'd64);

        // Trigger during boot wait is ignored
        cycles(20);
        splat = 1'b1;
        cycles(6);
        splat = 1'b0;
        cycles(300);
        check("boot_ignore_busy", 32'(test_busy), 32'd0);
        check("boot_ignore_runs", 32'(n_runs), 32'd0);

        // Interrupt becomes sticky irq_seen
        u_if.hpi_irq = 1'b1;
        cycles(3);
        u_if.hpi_irq = 1'b0;
        cycles(3);
        check("irq_seen_set", 32'(irq_seen), 32'd1);

        // Run 1: passing test with splat held high throughout
        base  = n_acc;
        splat = 1'b1;
        k = 0;
        while (u_if.hpi_csn && k < 30) begin @(negedge sys_clk); k++; end
        check("first_csn_low", 32'(u_if.hpi_csn), 32'd0);
        check("first_addr", 32'(u_if.hpi_address), 32'h2);
        check("first_data", 32'(hpi_data), 32'h1000);
        check("first_busy", 32'(test_busy), 32'd1);
        check("start_clears_irq", 32'(irq_seen), 32'd0);
        k = 0;
        while (u_if.hpi_wen && k < 20) begin @(negedge sys_clk); k++; end
        check("setup_len", 32'(k), 32'd2);
        k = 0;
        while (!u_if.hpi_wen && k < 20) begin @(negedge sys_clk); k++; end
        check("strobe_len", 32'(k), 32'd4);
        k = 0;
        while (!u_if.hpi_csn && k < 20) begin @(negedge sys_clk); k++; end
        check("hold_len", 32'(k), 32'd1);
        k = 0;
        while (!test_done && k < 2000) begin @(negedge sys_clk); k++; end
        check("run1_done", 32'(test_done), 32'd1);
        check("run1_pass", 32'(test_pass), 32'd1);
        check("run1_busy", 32'(test_busy), 32'd0);
        check("run1_accesses", 32'(n_acc - base), 32'd34);
        check("run1_word0", 32'(acc_data[(base + 1) % 256]), 32'h00FF);
        check("run1_word1", 32'(acc_data[(base + 2) % 256]), 32'h01FE);
        check("run1_word15", 32'(acc_data[(base + 16) % 256]), 32'h0FF0);
        for (int i = 0; i < 16; i++) begin
            exp_word = 16'((i << 8) | (255 - i));
            check($sformatf("run1_wr%0d", i), 32'(acc_data[(base + 1 + i) % 256]), 32'(exp_word));
            check($sformatf("run1_rdport%0d", i), 32'({acc_rnw[(base + 18 + i) % 256], acc_port[(base + 18 + i) % 256]}), 32'h4);
        end
        check("run1_rdptr_port", 32'(acc_port[(base + 17) % 256]), 32'h2);
        check("run1_rdptr_data", 32'(acc_data[(base + 17) % 256]), 32'h1000);
        cycles(2000);
        check("held_splat_runs", 32'(n_runs), 32'd1);
        check("held_splat_acc", 32'(n_acc - base), 32'd34);
        splat = 1'b0;
        cycles(5);

        // Run 2: word 5 corrupted on readback, mid-test edge ignored
        corrupt = 1'b1;
        base    = n_acc;
        splat   = 1'b1;
        k = 0;
        while (!test_busy && k < 20) begin @(negedge sys_clk); k++; end
        check("run2_busy", 32'(test_busy), 32'd1);
        check("run2_done_cleared", 32'(test_done), 32'd0);
        check("run2_pass_cleared", 32'(test_pass), 32'd0);
        k = 0;
        while ((n_acc - base) < 10 && k < 500) begin @(negedge sys_clk); k++; end
        splat = 1'b0;
        cycles(4);
        splat = 1'b1;
        cycles(4);
        k = 0;
        while (!test_done && k < 2000) begin @(negedge sys_clk); k++; end
        check("run2_done", 32'(test_done), 32'd1);
        check("run2_pass", 32'(test_pass), 32'd0);
        check("run2_accesses", 32'(n_acc - base), 32'd34);
        check("run2_runs", 32'(n_runs), 32'd2);
        n_rd = 0;
        for (int i = 0; i < 34; i++) if (acc_rnw[(base + i) % 256]) n_rd++;
        check("run2_reads", 32'(n_rd), 32'd16);
        splat = 1'b0;
        cycles(5);

        // Run 3: asynchronous reset during a read strobe
        corrupt = 1'b0;
        base    = n_acc;
        splat   = 1'b1;
        k = 0;
        while (!((n_acc - base) >= 20 && !u_if.hpi_oen) && k < 1000) begin
            @(negedge sys_clk); k++;
        end
        check("mid_rd_oen_low", 32'(u_if.hpi_oen), 32'd0);
        #2;
        usbreset = 1'b1;
        #1;
        check("areset_oen", 32'(u_if.hpi_oen), 32'd1);
        check("areset_csn", 32'(u_if.hpi_csn), 32'd1);
        check("areset_data_z", 32'(dut.w_doe), 32'd0);
        check("areset_busy", 32'(test_busy), 32'd0);
        check("areset_resetn", 32'(u_if.hpi_resetn), 32'd0);
        @(negedge sys_clk);
        splat    = 1'b0;
        usbreset = 1'b0;
        count_resetn_low(k);
        check("areset_hold_len", 32'(k), 32'd64);
        check("areset_done", 32'(test_done), 32'd0);

        check("protocol_viol", 32'(r_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
